tdm_shift_tx: RTL and testbench

Parametrised serial audio transmitter: accepts a full frame of parallel samples through a valid/ready handshake, double-buffers it, and on each frame-sync (lr_clk) rising edge shifts CHANNELS slots out MSB-first on a single data line. Generalises the two-channel bit-serial output stage to arbitrary sample width, slot width and channel count, and adds underrun handling. It sits between the mixer/summing datapath and the I2S/TDM pad.

---
 rtl/tdm_shift_tx_pkg.sv | 17 +
 rtl/tdm_shift_tx_if.sv | 12 +
 rtl/tdm_shift_tx_lr_edge_detect.sv | 30 +++
 rtl/tdm_shift_tx.sv | 109 ++++++++++
 tb/tb_tdm_shift_tx.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/tdm_shift_tx_pkg.sv
// Shared types and helpers for the TDM/I2S serial transmitter.
package tdm_tx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int MAX_CHANNELS = 8;
  localparam int MAX_WIDTH    = 32;

  // Width of the slot index; a single-slot frame still gets one bit.
  function automatic int slot_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/tdm_shift_tx_if.sv
// Parallel frame handshake between the mixer datapath and the serial transmitter.
interface tdm_shift_tx_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2
);
  logic [CHANNELS*WIDTH-1:0] sample_data;
  logic                      sample_valid;
  logic                      sample_ready;

  modport master (output sample_data, output sample_valid, input  sample_ready);
  modport slave  (input  sample_data, input  sample_valid, output sample_ready);
endinterface

// File: rtl/tdm_shift_tx_lr_edge_detect.sv
// Frame-sync rising-edge detector; TDM_SHIFT_TX_I2S_DELAY_EN adds the one-bit I2S delay.
module lr_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic lr_clk,
  output logic start
);
  logic prev_lr;
  logic rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_lr <= 1'b0;
    else        prev_lr <= lr_clk;
  end

  assign rise = lr_clk & ~prev_lr;

`ifdef TDM_SHIFT_TX_I2S_DELAY_EN
  logic rise_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rise_p0 <= 1'b0;
    else        rise_p0 <= rise;
  end

  assign start = rise_p0;
`else
  assign start = rise;
`endif
endmodule

// File: rtl/tdm_shift_tx.sv
// Double-buffered multi-slot serial transmitter (left-justified, or I2S when
// TDM_SHIFT_TX_I2S_DELAY_EN is defined). sd_out changes on the falling clock edge.
module tdm_shift_tx
  import tdm_tx_pkg::*;
#(
  parameter  int WIDTH     = 16,
  parameter  int SLOT_BITS = 32,
  parameter  int CHANNELS  = 2,
  localparam int SLOT_W    = slot_w(CHANNELS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lr_clk,
  tdm_shift_tx_if.slave     smp,
  output logic              sd_out,
  output logic [SLOT_W-1:0] slot_idx,
  output logic              busy,
  output logic              underrun
);
  localparam int                FW        = CHANNELS * WIDTH;
  localparam int                BW        = $clog2(SLOT_BITS);
  localparam logic [BW-1:0]     LAST_BIT  = BW'(SLOT_BITS - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CHANNELS - 1);

  state_t            state;
  logic              full;
  logic              start;
  logic              accept;
  logic              in_data;
  logic              data_bit;
  logic [BW-1:0]     bit_cnt;
  logic [SLOT_W-1:0] slot_cnt;
  logic [FW-1:0]     hold;
  logic [FW-1:0]     ordered;
  logic [FW-1:0]     sreg;

  lr_edge_detect u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .lr_clk (lr_clk),
    .start  (start)
  );

  assign smp.sample_ready = ~full;
  assign accept           = smp.sample_valid & ~full;
  assign slot_idx         = slot_cnt;

  // Channel 0 moves to the top of the shift register so the whole frame leaves MSB-first.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_order
    assign ordered[(CHANNELS-1-c)*WIDTH +: WIDTH] = hold[c*WIDTH +: WIDTH];
  end

  // Control: holding-buffer flag, slot/bit counters and frame state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      underrun <= 1'b0;
      full     <= 1'b0;
      bit_cnt  <= '0;
      slot_cnt <= '0;
    end else begin
      underrun <= 1'b0;
      if (accept) full <= 1'b1;
      if (start) begin
        full     <= accept;
        underrun <= ~full;
        state    <= SHIFT;
        busy     <= 1'b1;
        bit_cnt  <= '0;
        slot_cnt <= '0;
      end else if (state == SHIFT) begin
        if (bit_cnt == LAST_BIT) begin
          bit_cnt <= '0;
          if (slot_cnt == LAST_SLOT) begin
            state    <= IDLE;
            busy     <= 1'b0;
            slot_cnt <= '0;
          end else begin
            slot_cnt <= slot_cnt + 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  // Data: holding buffer and frame shift register; validity is tracked by full/state.
  always_ff @(posedge clk) begin
    if (accept) hold <= smp.sample_data;
    if (start) sreg <= full ? ordered : '0;
    else if (state == SHIFT && in_data) sreg <= sreg << 1;
  end

  assign in_data = (32'(bit_cnt) < 32'(WIDTH));

`ifdef TDM_SHIFT_TX_I2S_DELAY_EN
  assign data_bit = (state == SHIFT) & in_data & sreg[FW-1] & ~start;
`else
  assign data_bit = (state == SHIFT) & in_data & sreg[FW-1];
`endif

  // Output stage: half-cycle retiming onto the pad.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) sd_out <= 1'b0;
    else        sd_out <= data_bit;
  end
endmodule

// File: tb/tb_tdm_shift_tx.sv
// Scoreboard bench for tdm_shift_tx (WIDTH=16, SLOT_BITS=32, CHANNELS=2).
module tb_tdm_shift_tx;
  localparam int WIDTH     = 16;
  localparam int SLOT_BITS = 32;
  localparam int CHANNELS  = 2;
  localparam int FRAME     = SLOT_BITS * CHANNELS;
  localparam int SLOT_W    = tdm_tx_pkg::slot_w(CHANNELS);
`ifdef TDM_SHIFT_TX_I2S_DELAY_EN
  localparam int LEAD = 1;
`else
  localparam int LEAD = 0;
`endif

  typedef struct packed {
    logic              sd;
    logic              busy;
    logic              under;
    logic [SLOT_W-1:0] slot;
  } exp_t;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic              lr_clk = 1'b0;
  logic              sd_out;
  logic              busy;
  logic              underrun;
  logic [SLOT_W-1:0] slot_idx;

  tdm_shift_tx_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) smp ();

  tdm_shift_tx #(.WIDTH(WIDTH), .SLOT_BITS(SLOT_BITS), .CHANNELS(CHANNELS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .lr_clk   (lr_clk),
    .smp      (smp),
    .sd_out   (sd_out),
    .slot_idx (slot_idx),
    .busy     (busy),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int                         n_vec = 0;
  int                         n_bad = 0;
  exp_t                       q[$];
  bit                         m_full = 1'b0;
  bit                         m_prev = 1'b0;
  bit                         m_rd   = 1'b0;
  logic [CHANNELS*WIDTH-1:0]  m_hold = '0;
  logic [63:0]                cap    = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected per-cycle outputs for one frame, derived straight from the sample layout.
  task automatic push_frame(input logic [CHANNELS*WIDTH-1:0] d, input bit present);
    exp_t e;
    int   s;
    int   b;
    q.delete();
    for (int n = 0; n < FRAME; n++) begin
      s       = n / SLOT_BITS;
      b       = n % SLOT_BITS;
      e.sd    = (present && b < WIDTH) ? d[s*WIDTH + WIDTH-1-b] : 1'b0;
      e.busy  = 1'b1;
      e.under = (n == 0) && !present;
      e.slot  = SLOT_W'(s);
      q.push_back(e);
    end
  endtask

  task automatic cycle();
    exp_t e;
    bit   acc;
    bit   st;
    bit   force0;
    acc    = smp.sample_valid && !m_full;
    force0 = 1'b0;
`ifdef TDM_SHIFT_TX_I2S_DELAY_EN
    st     = m_rd;
    m_rd   = lr_clk && !m_prev;
    force0 = m_rd;
`else
    st     = lr_clk && !m_prev;
`endif
    if (st) begin
      push_frame(m_hold, m_full);
      m_full = acc;
    end else if (acc) begin
      m_full = 1'b1;
    end
    if (acc) m_hold = smp.sample_data;
    m_prev = lr_clk;
    @(posedge clk);
    #1;
    if (acc) smp.sample_valid = 1'b0;
    e = '0;
    if (q.size() > 0) e = q.pop_front();
    chk("busy",     64'(busy),             64'(e.busy));
    chk("underrun", 64'(underrun),         64'(e.under));
    chk("slot_idx", 64'(slot_idx),         64'(e.slot));
    chk("ready",    64'(smp.sample_ready), 64'(!m_full));
    @(negedge clk);
    #1;
    if (force0) e.sd = 1'b0;
    chk("sd_out", 64'(sd_out), 64'(e.sd));
    cap = {cap[62:0], sd_out};
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic offer(input logic [CHANNELS*WIDTH-1:0] d);
    smp.sample_data  = d;
    smp.sample_valid = 1'b1;
  endtask

  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sd",    64'(sd_out),           64'd0);
    chk("rst_ready", 64'(smp.sample_ready), 64'd1);
    chk("rst_busy",  64'(busy),             64'd0);
    chk("rst_under", 64'(underrun),         64'd0);
    chk("rst_slot",  64'(slot_idx),         64'd0);
    q.delete();
    m_full = 1'b0;
    m_prev = 1'b0;
    m_rd   = 1'b0;
    smp.sample_valid = 1'b0;
    lr_clk = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    smp.sample_data  = '0;
    smp.sample_valid = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_sd",    64'(sd_out),           64'd0);
    chk("reset_ready", 64'(smp.sample_ready), 64'd1);
    chk("reset_busy",  64'(busy),             64'd0);
    chk("reset_under", 64'(underrun),         64'd0);
    chk("reset_slot",  64'(slot_idx),         64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    run(2);

    // Basic frame, lr_clk falling mid-frame must be ignored.
    offer({16'h0001, 16'hA5F0});
    run(3);
    lr_clk = 1'b1;
    run(LEAD + 10);
    lr_clk = 1'b0;
    run(FRAME - 10);
    chk("frame1_bits", cap, 64'hA5F0_0000_0001_0000);
    run(3);

    // Underrun: nothing offered.
    lr_clk = 1'b1;
    run(LEAD + FRAME);
    chk("underrun_bits", cap, 64'h0);
    lr_clk = 1'b0;
    run(2);

    // Double buffering: second frame accepted during shift, third stalls.
    offer({16'h1234, 16'h8001});
    run(2);
    lr_clk = 1'b1;
    run(LEAD + 3);
    lr_clk = 1'b0;
    offer({16'h00FF, 16'hC3C3});
    run(2);
    offer({16'h7E7E, 16'h0F0F});
    run(FRAME);
    lr_clk = 1'b1;
    run(LEAD + FRAME);
    chk("frame2_bits", cap, 64'hC3C3_0000_00FF_0000);
    lr_clk = 1'b0;
    run(2);
    lr_clk = 1'b1;
    run(LEAD + FRAME);
    chk("frame3_bits", cap, 64'h0F0F_0000_7E7E_0000);
    lr_clk = 1'b0;
    run(2);

    // Frame sync at bit 20 truncates the running frame.
    offer({16'hFFFF, 16'h5555});
    run(2);
    lr_clk = 1'b1;
    run(LEAD + 5);
    lr_clk = 1'b0;
    offer({16'h0002, 16'h9ABC});
    run(15);
    lr_clk = 1'b1;
    run(LEAD + FRAME);
    chk("trunc_bits", cap, 64'h9ABC_0000_0002_0000);
    lr_clk = 1'b0;
    run(2);

    // Reset in the middle of a frame of ones, then an empty frame.
    offer({16'h0000, 16'hFFFF});
    run(2);
    lr_clk = 1'b1;
    run(LEAD + 10);
    reset_pulse();
    run(3);
    lr_clk = 1'b1;
    run(LEAD + FRAME);
    chk("post_rst_bits", cap, 64'h0);
    lr_clk = 1'b0;
    run(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
